// File: rtl/fractal_sync_req_tx_if.sv
// Handshake bundle between a core, the barrier request block and the sync tree.
// The slave modport is the block's view; the master modport is the environment's view.
interface fractal_sync_req_tx_if #(
    parameter int LVL_WIDTH = 4,
    parameter int ID_WIDTH  = 8
);
    logic                 core_req_valid_i;
    logic                 core_req_ready_o;
    logic [LVL_WIDTH-1:0] core_req_lvl_i;
    logic [ID_WIDTH-1:0]  core_req_id_i;
    logic                 core_rsp_valid_o;
    logic                 core_rsp_ready_i;
    logic                 core_rsp_error_o;
    logic                 fsync_req_valid_o;
    logic                 fsync_req_ready_i;
    logic [LVL_WIDTH-1:0] fsync_req_lvl_o;
    logic [ID_WIDTH-1:0]  fsync_req_id_o;
    logic                 fsync_wake_valid_i;
    logic [LVL_WIDTH-1:0] fsync_wake_lvl_i;
    logic [ID_WIDTH-1:0]  fsync_wake_id_i;
    logic                 fsync_wake_error_i;
    logic                 busy_o;

    modport slave (
        input  core_req_valid_i, core_req_lvl_i, core_req_id_i, core_rsp_ready_i,
        input  fsync_req_ready_i, fsync_wake_valid_i, fsync_wake_lvl_i,
        input  fsync_wake_id_i, fsync_wake_error_i,
        output core_req_ready_o, core_rsp_valid_o, core_rsp_error_o,
        output fsync_req_valid_o, fsync_req_lvl_o, fsync_req_id_o, busy_o
    );

    modport master (
        output core_req_valid_i, core_req_lvl_i, core_req_id_i, core_rsp_ready_i,
        output fsync_req_ready_i, fsync_wake_valid_i, fsync_wake_lvl_i,
        output fsync_wake_id_i, fsync_wake_error_i,
        input  core_req_ready_o, core_rsp_valid_o, core_rsp_error_o,
        input  fsync_req_valid_o, fsync_req_lvl_o, fsync_req_id_o, busy_o
    );
endinterface

// File: rtl/fractal_sync_req_tx.sv
// Core-side barrier request engine: forwards one barrier command to the sync tree,
// waits for the matching wake (or a timeout) and returns a completion to the core.
module fractal_sync_req_tx #(
    parameter int LVL_WIDTH      = 4,
    parameter int ID_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fractal_sync_req_tx_if.slave bus
);

    localparam int CNT_RAW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W    = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t               state;
    logic [LVL_WIDTH-1:0] lvl_q;
    logic [ID_WIDTH-1:0]  id_q;
    logic                 err_q;
    logic [CNT_W-1:0]     cnt;
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic                 fsync_valid_q;
    logic                 busy_q;

    logic wake_match;
    logic timeout_hit;

    assign wake_match  = bus.fsync_wake_valid_i
                      && (bus.fsync_wake_lvl_i == lvl_q)
                      && (bus.fsync_wake_id_i == id_q);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            lvl_q         <= '0;
            id_q          <= '0;
            err_q         <= 1'b0;
            cnt           <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            fsync_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.core_req_valid_i && req_ready_q) begin
                        lvl_q       <= bus.core_req_lvl_i;
                        id_q        <= bus.core_req_id_i;
                        cnt         <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        // Level 0 names no tree level, so it fails locally without a request.
                        if (bus.core_req_lvl_i == '0) begin
                            state       <= RESP;
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state         <= SEND;
                            err_q         <= 1'b0;
                            fsync_valid_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (bus.fsync_req_ready_i) begin
                        state         <= WAIT;
                        cnt           <= '0;
                        fsync_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    // A matching wake wins over a timeout expiring in the same cycle.
                    if (wake_match) begin
                        state       <= RESP;
                        err_q       <= bus.fsync_wake_error_i;
                        rsp_valid_q <= 1'b1;
                    end else if (timeout_hit) begin
                        state       <= RESP;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt != '1)) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RESP: begin
                    if (bus.core_rsp_ready_i) begin
                        state       <= IDLE;
                        err_q       <= 1'b0;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    req_ready_q   <= 1'b1;
                    rsp_valid_q   <= 1'b0;
                    fsync_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_req_ready_o  = req_ready_q;
    assign bus.core_rsp_valid_o  = rsp_valid_q;
    assign bus.core_rsp_error_o  = rsp_valid_q & err_q;
    assign bus.fsync_req_valid_o = fsync_valid_q;
    // Command fields are only driven while a request is presented, zero otherwise.
    assign bus.fsync_req_lvl_o   = fsync_valid_q ? lvl_q : '0;
    assign bus.fsync_req_id_o    = fsync_valid_q ? id_q : '0;
    assign bus.busy_o            = busy_q;

endmodule

// File: tb/tb_fractal_sync_req_tx.sv
// Directed bench for fractal_sync_req_tx with an 8-cycle timeout.
module tb_fractal_sync_req_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   fs_hs  = 0;
    int   rsp_hs = 0;

    always #5 clk = ~clk;

    fractal_sync_req_tx_if #(.LVL_WIDTH(4), .ID_WIDTH(8)) bus ();

    fractal_sync_req_tx #(
        .LVL_WIDTH(4),
        .ID_WIDTH(8),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always @(posedge clk) begin
        if (!rst && bus.fsync_req_valid_o && bus.fsync_req_ready_i) fs_hs++;
        if (!rst && bus.core_rsp_valid_o && bus.core_rsp_ready_i) rsp_hs++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(bus.core_req_ready_o), 32'd1);
        chk({tag, "_rspv"},  32'(bus.core_rsp_valid_o), 32'd0);
        chk({tag, "_fsv"},   32'(bus.fsync_req_valid_o), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy_o), 32'd0);
    endtask

    task automatic send_cmd(input logic [3:0] lvl, input logic [7:0] id);
        bus.core_req_valid_i = 1'b1;
        bus.core_req_lvl_i   = lvl;
        bus.core_req_id_i    = id;
        step();
        bus.core_req_valid_i = 1'b0;
        bus.core_req_lvl_i   = '0;
        bus.core_req_id_i    = '0;
    endtask

    task automatic wake(input logic v, input logic [3:0] lvl, input logic [7:0] id, input logic e);
        bus.fsync_wake_valid_i = v;
        bus.fsync_wake_lvl_i   = lvl;
        bus.fsync_wake_id_i    = id;
        bus.fsync_wake_error_i = e;
    endtask

    task automatic consume(input string tag);
        bus.core_rsp_ready_i = 1'b1;
        step();
        bus.core_rsp_ready_i = 1'b0;
        chk_idle(tag);
    endtask

    initial begin
        bus.core_req_valid_i  = 1'b0;
        bus.core_req_lvl_i    = '0;
        bus.core_req_id_i     = '0;
        bus.core_rsp_ready_i  = 1'b0;
        bus.fsync_req_ready_i = 1'b0;
        wake(1'b0, 4'd0, 8'd0, 1'b0);

        // Reset state
        step();
        step();
        chk_idle("rst");
        chk("rst_err", 32'(bus.core_rsp_error_o), 32'd0);
        chk("rst_lvl", 32'(bus.fsync_req_lvl_o), 32'd0);
        chk("rst_id",  32'(bus.fsync_req_id_o), 32'd0);
        rst = 1'b0;
        step();
        chk_idle("post_rst");

        // Command lvl=2 id=0x15, tree stalls for 3 cycles
        send_cmd(4'd2, 8'h15);
        for (int i = 0; i < 4; i++) begin
            chk("send_fsv",   32'(bus.fsync_req_valid_o), 32'd1);
            chk("send_lvl",   32'(bus.fsync_req_lvl_o), 32'd2);
            chk("send_id",    32'(bus.fsync_req_id_o), 32'h15);
            chk("send_ready", 32'(bus.core_req_ready_o), 32'd0);
            chk("send_busy",  32'(bus.busy_o), 32'd1);
            if (i < 3) step();
        end
        bus.fsync_req_ready_i = 1'b1;
        step();
        bus.fsync_req_ready_i = 1'b0;
        chk("wait_fsv",  32'(bus.fsync_req_valid_o), 32'd0);
        chk("wait_busy", 32'(bus.busy_o), 32'd1);
        chk("one_hs",    32'(fs_hs), 32'd1);

        // Non-matching wake ignored, matching wake completes
        wake(1'b1, 4'd2, 8'h16, 1'b0);
        step();
        wake(1'b0, 4'd0, 8'd0, 1'b0);
        chk("nomatch_rspv", 32'(bus.core_rsp_valid_o), 32'd0);
        chk("nomatch_busy", 32'(bus.busy_o), 32'd1);
        wake(1'b1, 4'd2, 8'h15, 1'b0);
        step();
        wake(1'b0, 4'd0, 8'd0, 1'b0);
        chk("match_rspv",  32'(bus.core_rsp_valid_o), 32'd1);
        chk("match_err",   32'(bus.core_rsp_error_o), 32'd0);
        chk("match_ready", 32'(bus.core_req_ready_o), 32'd0);
        step();
        chk("resp_hold_v", 32'(bus.core_rsp_valid_o), 32'd1);
        chk("resp_hold_e", 32'(bus.core_rsp_error_o), 32'd0);
        consume("done1");

        // Timeout after 8 cycles; wake during the SEND handshake cycle is ignored
        send_cmd(4'd3, 8'h40);
        bus.fsync_req_ready_i = 1'b1;
        wake(1'b1, 4'd3, 8'h40, 1'b0);
        step();
        bus.fsync_req_ready_i = 1'b0;
        wake(1'b0, 4'd0, 8'd0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            chk("to_pending", 32'(bus.core_rsp_valid_o), 32'd0);
            step();
        end
        chk("to_pending", 32'(bus.core_rsp_valid_o), 32'd0);
        step();
        chk("to_rspv", 32'(bus.core_rsp_valid_o), 32'd1);
        chk("to_err",  32'(bus.core_rsp_error_o), 32'd1);
        consume("done2");

        // Matching wake with error=1 in the timeout cycle
        send_cmd(4'd1, 8'h07);
        bus.fsync_req_ready_i = 1'b1;
        step();
        bus.fsync_req_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("tie1_pending", 32'(bus.core_rsp_valid_o), 32'd0);
        wake(1'b1, 4'd1, 8'h07, 1'b1);
        step();
        wake(1'b0, 4'd0, 8'd0, 1'b0);
        chk("tie1_rspv", 32'(bus.core_rsp_valid_o), 32'd1);
        chk("tie1_err",  32'(bus.core_rsp_error_o), 32'd1);
        consume("done3");
        step();
        chk("tie1_single", 32'(bus.core_rsp_valid_o), 32'd0);

        // Matching wake with error=0 in the timeout cycle: the wake wins
        send_cmd(4'd1, 8'h08);
        bus.fsync_req_ready_i = 1'b1;
        step();
        bus.fsync_req_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) step();
        wake(1'b1, 4'd1, 8'h08, 1'b0);
        step();
        wake(1'b0, 4'd0, 8'd0, 1'b0);
        chk("tie0_rspv", 32'(bus.core_rsp_valid_o), 32'd1);
        chk("tie0_err",  32'(bus.core_rsp_error_o), 32'd0);
        consume("done4");

        // Level 0 fails locally without a tree request
        send_cmd(4'd0, 8'h22);
        chk("lvl0_fsv",  32'(bus.fsync_req_valid_o), 32'd0);
        chk("lvl0_rspv", 32'(bus.core_rsp_valid_o), 32'd1);
        chk("lvl0_err",  32'(bus.core_rsp_error_o), 32'd1);
        chk("lvl0_busy", 32'(bus.busy_o), 32'd1);
        consume("done5");
        chk("lvl0_nohs", 32'(fs_hs), 32'd4);

        // Reset in WAIT, then a matching wake
        send_cmd(4'd5, 8'h33);
        bus.fsync_req_ready_i = 1'b1;
        step();
        bus.fsync_req_ready_i = 1'b0;
        step();
        chk("rw_busy", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        wake(1'b1, 4'd5, 8'h33, 1'b0);
        step();
        rst = 1'b0;
        chk_idle("rw_rst");
        step();
        wake(1'b0, 4'd0, 8'd0, 1'b0);
        chk_idle("rw_after");
        step();
        chk_idle("rw_late");

        chk("fs_hs_total",  32'(fs_hs), 32'd5);
        chk("rsp_hs_total", 32'(rsp_hs), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
